// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream, writes big-endian words into instruction memory,
// verifies the trailing XOR checksum, and keeps the core in reset until the load succeeds.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset_global,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        reload,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_reset_n,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    StHdrHi,
    StHdrLo,
    StData,
    StCheck,
    StDone,
    StError
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] word_q, word_d;
  logic [7:0]  xor_q, xor_d;
  logic        byte_ready_q, byte_ready_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        cpu_reset_n_q, cpu_reset_n_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        xfer;
  logic [15:0] hdr_count;

  assign xfer      = byte_valid & byte_ready_q;
  assign hdr_count = {count_q[15:8], byte_in};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    idx_d      = idx_q;
    word_d     = word_q;
    xor_d      = xor_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    unique case (state_q)
      StHdrHi: begin
        if (xfer) begin
          count_d[15:8] = byte_in;
          xor_d         = xor_q ^ byte_in;
          state_d       = StHdrLo;
        end
      end
      StHdrLo: begin
        if (xfer) begin
          count_d[7:0] = byte_in;
          xor_d        = xor_q ^ byte_in;
          if ({16'd0, hdr_count} > MAX_WORDS) begin
            state_d = StError;
          end else if (hdr_count == 16'd0) begin
            state_d = StCheck;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          xor_d  = xor_q ^ byte_in;
          idx_d  = idx_q + 2'd1;
          word_d = {word_q[15:0], byte_in};
          if (idx_q == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
            wr_data_d  = {word_q, byte_in};
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_q + 16'd1 == count_q) begin
              state_d = StCheck;
            end
          end
        end
      end
      StCheck: begin
        if (xfer) begin
          state_d = (byte_in == xor_q) ? StDone : StError;
        end
      end
      StDone, StError: begin
        if (reload) begin
          state_d    = StHdrHi;
          xor_d      = 8'd0;
          word_cnt_d = 16'd0;
          idx_d      = 2'd0;
        end
      end
      default: state_d = StHdrHi;
    endcase

    // Status outputs follow the state being entered so they change on the deciding edge.
    byte_ready_d  = (state_d != StDone) && (state_d != StError);
    done_d        = (state_d == StDone);
    error_d       = (state_d == StError);
    cpu_reset_n_d = (state_d == StDone);
  end

  always_ff @(posedge clock or negedge reset_global) begin
    if (!reset_global) begin
      state_q       <= StHdrHi;
      count_q       <= 16'd0;
      word_cnt_q    <= 16'd0;
      idx_q         <= 2'd0;
      word_q        <= 24'd0;
      xor_q         <= 8'd0;
      byte_ready_q  <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= BASE_ADDR;
      wr_data_q     <= 32'd0;
      cpu_reset_n_q <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      word_cnt_q    <= word_cnt_d;
      idx_q         <= idx_d;
      word_q        <= word_d;
      xor_q         <= xor_d;
      byte_ready_q  <= byte_ready_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      cpu_reset_n_q <= cpu_reset_n_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign byte_ready  = byte_ready_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign cpu_reset_n = cpu_reset_n_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are built from random words, expected writes are
// queued per frame and a negedge monitor pops and compares every write strobe.
module tb_imem_loader;

  localparam logic [31:0] Base     = 32'h0000_0100;
  localparam int unsigned MaxWords = 256;

  logic        clock = 1'b0;
  logic        reset_global;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        reload;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_reset_n;
  logic        done;
  logic        error;

  imem_loader #(
    .BASE_ADDR(Base),
    .MAX_WORDS(MaxWords)
  ) dut (
    .clock       (clock),
    .reset_global(reset_global),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .reload      (reload),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .cpu_reset_n (cpu_reset_n),
    .done        (done),
    .error       (error)
  );

  always #5 clock = ~clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] words[256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected write.
  always @(negedge clock) begin
    if (reset_global === 1'b1 && wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", wr_addr, mon_e[63:32]);
        check("wr_data", wr_data, mon_e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    bit rdy;
    byte_valid = 1'b0;
    if (gap > 0) repeat ($urandom_range(0, gap)) @(posedge clock);
    #1;
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      rdy = byte_ready;
      @(posedge clock);
      #1;
      ok = rdy;
    end
    byte_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_byte_timeout: got no transfer of %h expected one within 64 cycles", b);
    end
  endtask

  // Reference frame: header, big-endian words, XOR of all prior bytes (optionally corrupted).
  task automatic send_frame(input int n, input bit bad, input int gap);
    logic [7:0]  x = 8'd0;
    logic [15:0] nn = 16'(n);
    logic [7:0]  b;
    for (int i = 0; i < n; i++) exp_q.push_back({Base + 32'(4 * i), words[i]});
    b = nn[15:8]; x ^= b; send_byte(b, gap);
    b = nn[7:0];  x ^= b; send_byte(b, gap);
    for (int i = 0; i < n; i++) begin
      for (int k = 3; k >= 0; k--) begin
        b = 8'(words[i] >> (8 * k));
        x ^= b;
        send_byte(b, gap);
      end
    end
    send_byte(bad ? (x ^ 8'h01) : x, gap);
  endtask

  task automatic check_state(input string name, input bit exp_done, input bit exp_err);
    check({name, ".done"}, done, exp_done);
    check({name, ".error"}, error, exp_err);
    check({name, ".cpu_reset_n"}, cpu_reset_n, exp_done);
    check({name, ".byte_ready"}, byte_ready, !(exp_done || exp_err));
    check({name, ".pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, ".byte_ready"}, byte_ready, 0);
    check({name, ".wr_en"}, wr_en, 0);
    check({name, ".wr_addr"}, wr_addr, Base);
    check({name, ".wr_data"}, wr_data, 0);
    check({name, ".cpu_reset_n"}, cpu_reset_n, 0);
    check({name, ".done"}, done, 0);
    check({name, ".error"}, error, 0);
  endtask

  task automatic do_reload();
    @(negedge clock);
    reload = 1'b1;
    @(posedge clock);
    #1;
    reload = 1'b0;
    check("reload.done", done, 0);
    check("reload.error", error, 0);
    check("reload.cpu_reset_n", cpu_reset_n, 0);
    check("reload.byte_ready", byte_ready, 1);
  endtask

  task automatic stall_bytes(input int k);
    byte_in    = 8'($urandom);
    byte_valid = 1'b1;
    repeat (k) @(posedge clock);
    #1;
    byte_valid = 1'b0;
  endtask

  initial begin
    reset_global = 1'b0;
    byte_in      = 8'd0;
    byte_valid   = 1'b0;
    reload       = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_vals("reset");
    @(negedge clock);
    reset_global = 1'b1;
    @(posedge clock);
    #1;
    check("ready_after_reset", byte_ready, 1);

    words[0] = 32'h2008_0005;
    send_frame(1, 1'b0, 0);
    check_state("single", 1, 0);

    do_reload();
    send_frame(0, 1'b0, 0);
    check_state("empty", 1, 0);

    do_reload();
    send_frame(1, 1'b1, 0);
    check_state("badsum", 0, 1);
    stall_bytes(5);
    check_state("badsum_hold", 0, 1);

    do_reload();
    for (int i = 0; i < 2; i++) words[i] = $urandom;
    send_frame(2, 1'b0, 1);
    check_state("after_error", 1, 0);

    // 257 words is one past the limit.
    do_reload();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check_state("oversize", 0, 1);
    stall_bytes(5);
    check_state("oversize_hold", 0, 1);

    do_reload();
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    send_frame(3, 1'b0, 3);
    check_state("multi_gaps", 1, 0);

    do_reload();
    for (int i = 0; i < 256; i++) words[i] = $urandom;
    send_frame(256, 1'b0, 0);
    check_state("max_words", 1, 0);

    for (int t = 0; t < 6; t++) begin
      int n = $urandom_range(1, 8);
      bit bad = ($urandom_range(0, 3) == 0);
      do_reload();
      for (int i = 0; i < n; i++) words[i] = $urandom;
      send_frame(n, bad, 2);
      check_state("random", !bad, bad);
    end

    // Abort two bytes into the second word; only the first word may be written.
    do_reload();
    for (int i = 0; i < 2; i++) words[i] = $urandom;
    exp_q.push_back({Base, words[0]});
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int k = 3; k >= 0; k--) send_byte(8'(words[0] >> (8 * k)), 0);
    send_byte(words[1][31:24], 0);
    send_byte(words[1][23:16], 0);
    reset_global = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    check("mid_reset.pending_writes", exp_q.size(), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_global = 1'b1;
    for (int i = 0; i < 2; i++) words[i] = $urandom;
    send_frame(2, 1'b0, 1);
    check_state("after_mid_reset", 1, 0);

    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
